// File: rtl/miriscv_ram_pkg.sv
// Shared types for the two-master RAM arbiter: master index, default RAM size
// and the RAM data-port command record.
package miriscv_ram_pkg;

    typedef enum logic {
        MASTER_CORE = 1'b0,
        MASTER_DMA  = 1'b1
    } master_e;

    localparam int RAM_SIZE_DEFAULT = 256;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } ram_cmd_t;

endpackage

// File: rtl/miriscv_rr_arb2.sv
// Two-way round-robin grant: a lone request wins at once, a tie goes to the
// master that was not granted last. The pointer moves only when advance_i is set.
module miriscv_rr_arb2
    import miriscv_ram_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    master_e r_last;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last <= MASTER_DMA;
        end else if (advance_i) begin
            r_last <= gnt_o[1] ? MASTER_DMA : MASTER_CORE;
        end
    end

    always_comb begin
        gnt_o = 2'b00;
        if (!rst_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = (r_last == MASTER_DMA) ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/miriscv_ram_arbiter.sv
// Arbitrates the core LSU and the loader/DMA onto one single-port RAM with a
// one-cycle response; out-of-range accesses are granted but answered with err.
module miriscv_ram_arbiter
    import miriscv_ram_pkg::*;
#(
    parameter int RAM_SIZE = RAM_SIZE_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic        m0_err_o,
    output logic [31:0] m0_rdata_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic        m1_err_o,
    output logic [31:0] m1_rdata_o,

    output logic        ram_req_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_be_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i
);

    localparam logic [31:0] RAM_LIMIT = 32'(RAM_SIZE);

    logic [1:0] w_gnt;
    logic       w_any_gnt;
    logic       w_in_range;
    ram_cmd_t   w_m0_cmd, w_m1_cmd, w_sel_cmd, w_ram_cmd;
    logic       w_rsp_vld;

    logic       r_rsp_vld;
    master_e    r_rsp_owner;
    logic       r_rsp_err;

    assign w_any_gnt = |w_gnt;

    miriscv_rr_arb2 u_rr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     ({m1_req_i, m0_req_i}),
        .advance_i (w_any_gnt),
        .gnt_o     (w_gnt)
    );

    assign m0_gnt_o = w_gnt[0];
    assign m1_gnt_o = w_gnt[1];

    assign w_m0_cmd = '{req: m0_req_i, we: m0_we_i, be: m0_be_i, addr: m0_addr_i, wdata: m0_wdata_i};
    assign w_m1_cmd = '{req: m1_req_i, we: m1_we_i, be: m1_be_i, addr: m1_addr_i, wdata: m1_wdata_i};
    assign w_sel_cmd  = w_gnt[1] ? w_m1_cmd : w_m0_cmd;
    assign w_in_range = (w_sel_cmd.addr < RAM_LIMIT);

    // Out-of-range grants still show the command fields but never strobe the RAM.
    always_comb begin
        w_ram_cmd = '0;
        if (w_any_gnt) begin
            w_ram_cmd     = w_sel_cmd;
            w_ram_cmd.req = w_in_range;
            w_ram_cmd.we  = w_sel_cmd.we & w_in_range;
        end
    end

    assign ram_req_o   = w_ram_cmd.req;
    assign ram_we_o    = w_ram_cmd.we;
    assign ram_be_o    = w_ram_cmd.be;
    assign ram_addr_o  = w_ram_cmd.addr;
    assign ram_wdata_o = w_ram_cmd.wdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rsp_vld   <= 1'b0;
            r_rsp_owner <= MASTER_CORE;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_vld   <= w_any_gnt;
            r_rsp_owner <= w_gnt[1] ? MASTER_DMA : MASTER_CORE;
            r_rsp_err   <= ~w_in_range;
        end
    end

    // A response due in a cycle where reset is asserted is dropped.
    assign w_rsp_vld = r_rsp_vld & ~rst_i;

    assign m0_rvalid_o = w_rsp_vld && (r_rsp_owner == MASTER_CORE);
    assign m1_rvalid_o = w_rsp_vld && (r_rsp_owner == MASTER_DMA);
    assign m0_err_o    = m0_rvalid_o & r_rsp_err;
    assign m1_err_o    = m1_rvalid_o & r_rsp_err;
    assign m0_rdata_o  = (m0_rvalid_o && !r_rsp_err) ? ram_rdata_i : 32'h0;
    assign m1_rdata_o  = (m1_rvalid_o && !r_rsp_err) ? ram_rdata_i : 32'h0;

endmodule

// File: tb/tb_miriscv_ram_arbiter.sv
// Directed per-cycle vectors for the RAM arbiter against a small registered
// RAM model, plus hand-written checks of the command fields.
module tb_miriscv_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_req, ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    miriscv_ram_arbiter #(.RAM_SIZE(256)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_err_o(m0_err), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_err_o(m1_err), .m1_rdata_o(m1_rdata),
        .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_be_o(ram_be), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    // 256-byte RAM, registered read returning pre-write contents.
    logic [31:0] mem [64];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[8] = 32'h11223344;
        ram_rdata = 32'h0;
    end
    always @(posedge clk) begin
        if (ram_req) begin
            ram_rdata <= mem[ram_addr[7:2]];
            if (ram_we)
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr[7:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
        end
    end

    typedef struct {
        logic        rst;
        logic        r0, we0;
        logic [3:0]  be0;
        logic [31:0] a0, d0;
        logic        r1, we1;
        logic [3:0]  be1;
        logic [31:0] a1, d1;
        logic [1:0]  gnt;
        logic        ram;
        logic [1:0]  rv, err;
        logic [31:0] rd0, rd1;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst_v,
                       input logic r0, input logic we0, input logic [3:0] be0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic we1, input logic [3:0] be1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic [1:0] gnt, input logic ram, input logic [1:0] rv, input logic [1:0] err,
                       input logic [31:0] rd0, input logic [31:0] rd1);
        vec_t v;
        v.rst = rst_v; v.r0 = r0; v.we0 = we0; v.be0 = be0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.we1 = we1; v.be1 = be1; v.a1 = a1; v.d1 = d1;
        v.gnt = gnt; v.ram = ram; v.rv = rv; v.err = err; v.rd0 = rd0; v.rd1 = rd1;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst_v,
                         input logic r0, input logic we0, input logic [3:0] be0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic we1, input logic [3:0] be1, input logic [31:0] a1, input logic [31:0] d1);
        rst = rst_v;
        m0_req = r0; m0_we = we0; m0_be = be0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = we1; m1_be = be1; m1_addr = a1; m1_wdata = d1;
    endtask

    initial begin
        drive(1'b1, 1'b1, 1'b1, 4'hF, 32'h10, 32'h1, 1'b1, 1'b1, 4'hF, 32'h20, 32'h2);

        // Reset state: everything quiet even with both masters requesting.
        @(posedge clk); #1; @(posedge clk); #5;
        chk("rst_gnt",   {30'h0, m1_gnt, m0_gnt}, 32'h0);
        chk("rst_ram",   {ram_req, ram_we, ram_be}, 32'h0);
        chk("rst_addr",  ram_addr, 32'h0);
        chk("rst_wdata", ram_wdata, 32'h0);
        chk("rst_rsp",   {m1_rvalid, m1_err, m0_rvalid, m0_err}, 32'h0);

        //    rst  r0 we0 be0   a0      d0             r1 we1 be1   a1       d1            gnt    ram  rv     err    rd0            rd1
        add(1, 1,0,4'hF,32'h10, 32'h0,         1,0,4'hF,32'h20, 32'h0,        2'b00, 0, 2'b00, 2'b00, 32'h0,        32'h0);
        add(0, 1,1,4'hF,32'h10, 32'hDEADBEEF,  0,0,4'h0,32'h0,  32'h0,        2'b01, 1, 2'b00, 2'b00, 32'h0,        32'h0);
        add(0, 1,0,4'hF,32'h10, 32'h0,         0,0,4'h0,32'h0,  32'h0,        2'b01, 1, 2'b01, 2'b00, 32'h0,        32'h0);
        add(0, 0,0,4'h0,32'h0,  32'h0,         0,0,4'h0,32'h0,  32'h0,        2'b00, 0, 2'b01, 2'b00, 32'hDEADBEEF, 32'h0);
        // contention right after reset: m0, m1, m0, m1
        add(1, 1,0,4'hF,32'h10, 32'h0,         1,0,4'hF,32'h20, 32'h0,        2'b00, 0, 2'b00, 2'b00, 32'h0,        32'h0);
        add(0, 1,0,4'hF,32'h10, 32'h0,         1,0,4'hF,32'h20, 32'h0,        2'b01, 1, 2'b00, 2'b00, 32'h0,        32'h0);
        add(0, 1,0,4'hF,32'h10, 32'h0,         1,0,4'hF,32'h20, 32'h0,        2'b10, 1, 2'b01, 2'b00, 32'hDEADBEEF, 32'h0);
        add(0, 1,0,4'hF,32'h10, 32'h0,         1,0,4'hF,32'h20, 32'h0,        2'b01, 1, 2'b10, 2'b00, 32'h0,        32'h11223344);
        add(0, 1,0,4'hF,32'h10, 32'h0,         1,0,4'hF,32'h20, 32'h0,        2'b10, 1, 2'b01, 2'b00, 32'hDEADBEEF, 32'h0);
        add(0, 0,0,4'h0,32'h0,  32'h0,         0,0,4'h0,32'h0,  32'h0,        2'b00, 0, 2'b10, 2'b00, 32'h0,        32'h11223344);
        // out-of-range write, then byte-enable write and back-to-back read
        add(0, 0,0,4'h0,32'h0,  32'h0,         1,1,4'hF,32'h100,32'hCAFEF00D, 2'b10, 0, 2'b00, 2'b00, 32'h0,        32'h0);
        add(0, 1,1,4'h2,32'h20, 32'h0000AB00,  0,0,4'h0,32'h0,  32'h0,        2'b01, 1, 2'b10, 2'b10, 32'h0,        32'h0);
        add(0, 1,0,4'hF,32'h20, 32'h0,         0,0,4'h0,32'h0,  32'h0,        2'b01, 1, 2'b01, 2'b00, 32'h11223344, 32'h0);
        add(0, 0,0,4'h0,32'h0,  32'h0,         1,0,4'hF,32'h0,  32'h0,        2'b10, 1, 2'b01, 2'b00, 32'h1122AB44, 32'h0);
        add(0, 0,0,4'h0,32'h0,  32'h0,         0,0,4'h0,32'h0,  32'h0,        2'b00, 0, 2'b10, 2'b00, 32'h0,        32'h0);
        // reset right after a grant drops the response; next tie goes to m0
        add(0, 1,0,4'hF,32'h10, 32'h0,         0,0,4'h0,32'h0,  32'h0,        2'b01, 1, 2'b00, 2'b00, 32'h0,        32'h0);
        add(1, 1,0,4'hF,32'h10, 32'h0,         1,0,4'hF,32'h10, 32'h0,        2'b00, 0, 2'b00, 2'b00, 32'h0,        32'h0);
        add(0, 1,0,4'hF,32'h10, 32'h0,         1,0,4'hF,32'h10, 32'h0,        2'b01, 1, 2'b00, 2'b00, 32'h0,        32'h0);
        add(0, 0,0,4'h0,32'h0,  32'h0,         0,0,4'h0,32'h0,  32'h0,        2'b00, 0, 2'b01, 2'b00, 32'hDEADBEEF, 32'h0);
        // idle cycles keep the pointer: after m0 wins alone, a later tie goes to m1
        add(0, 1,0,4'hF,32'h10, 32'h0,         0,0,4'h0,32'h0,  32'h0,        2'b01, 1, 2'b00, 2'b00, 32'h0,        32'h0);
        add(0, 0,0,4'h0,32'h0,  32'h0,         0,0,4'h0,32'h0,  32'h0,        2'b00, 0, 2'b01, 2'b00, 32'hDEADBEEF, 32'h0);
        add(0, 0,0,4'h0,32'h0,  32'h0,         0,0,4'h0,32'h0,  32'h0,        2'b00, 0, 2'b00, 2'b00, 32'h0,        32'h0);
        add(0, 1,0,4'hF,32'h10, 32'h0,         1,0,4'hF,32'h10, 32'h0,        2'b10, 1, 2'b00, 2'b00, 32'h0,        32'h0);
        add(0, 0,0,4'h0,32'h0,  32'h0,         0,0,4'h0,32'h0,  32'h0,        2'b00, 0, 2'b10, 2'b00, 32'h0,        32'hDEADBEEF);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            drive(vecs[i].rst, vecs[i].r0, vecs[i].we0, vecs[i].be0, vecs[i].a0, vecs[i].d0,
                  vecs[i].r1, vecs[i].we1, vecs[i].be1, vecs[i].a1, vecs[i].d1);
            #4;
            chk($sformatf("v%0d_gnt", i),    {30'h0, m1_gnt, m0_gnt}, {30'h0, vecs[i].gnt});
            chk($sformatf("v%0d_ramreq", i), {31'h0, ram_req}, {31'h0, vecs[i].ram});
            chk($sformatf("v%0d_rvalid", i), {30'h0, m1_rvalid, m0_rvalid}, {30'h0, vecs[i].rv});
            chk($sformatf("v%0d_err", i),    {30'h0, m1_err, m0_err}, {30'h0, vecs[i].err});
            chk($sformatf("v%0d_rdata0", i), m0_rdata, vecs[i].rd0);
            chk($sformatf("v%0d_rdata1", i), m1_rdata, vecs[i].rd1);
        end

        // Command fields of a granted partial write, then read it back-to-back.
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 4'h5, 32'h24, 32'h5A5A5A5A);
        #4;
        chk("wr_we",    {31'h0, ram_we}, 32'h1);
        chk("wr_be",    {28'h0, ram_be}, 32'h5);
        chk("wr_addr",  ram_addr, 32'h24);
        chk("wr_wdata", ram_wdata, 32'h5A5A5A5A);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h24, 32'h0);
        #4;
        chk("rd_we",     {31'h0, ram_we}, 32'h0);
        chk("rd_addr",   ram_addr, 32'h24);
        chk("wr_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h2);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #4;
        chk("rd_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h2);
        chk("rd_rdata",  m1_rdata, 32'h005A005A);
        chk("idle_ram",  {ram_req, ram_we, ram_be}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
